// File: rtl/cdb_arbiter_rr_pkg.sv
// Shared CDB definitions: functional-unit mix, default widths and packet types.
package sys_defs;

    localparam int NUM_FU_ALU  = 4;
    localparam int NUM_FU_MULT = 2;
    localparam int NUM_FU_LOAD = 2;
    localparam int N           = 3;

    localparam int NUM_REQ_DEF   = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
    localparam int PRF_IDX_W_DEF = 6;
    localparam int ROB_IDX_W_DEF = 5;
    localparam int DATA_W_DEF    = 32;

    typedef struct packed {
        logic [PRF_IDX_W_DEF-1:0] prf_idx;
        logic [ROB_IDX_W_DEF-1:0] rob_idx;
        logic [DATA_W_DEF-1:0]    value;
    } FU_REQ_PACKET;

    typedef struct packed {
        logic                     valid;
        logic [PRF_IDX_W_DEF-1:0] prf_idx;
        logic [ROB_IDX_W_DEF-1:0] rob_idx;
        logic [DATA_W_DEF-1:0]    value;
    } CDB_LANE_PACKET;

    // Index width that stays legal (>= 1 bit) for single-entry structures.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_fifo.sv
// cdb_req_fifo: private holding FIFO for one FU result port; ready is decoded
// from the registered count only, so a same-cycle pop never frees a slot early.
module cdb_req_fifo
    import sys_defs::*;
#(
    parameter int  DEPTH = 2,
    parameter type pkt_t = FU_REQ_PACKET,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  pkt_t             push_data_i,
    input  logic             pop_i,
    output pkt_t             head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ready_o
);

    localparam int PTR_W = clog2_min1(DEPTH);

    pkt_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign ready_o = (count_q < CNT_W'(DEPTH));
    assign do_push = push_i & ready_o & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cdb_arbiter_rr.sv
// cdb_arbiter_rr: per-FU holding FIFOs feeding NUM_LANES registered CDB lanes.
// Default is rotating priority; defining CDB_AGE_PRIO_EN ranks heads by ROB age instead.
module cdb_arbiter_rr
    import sys_defs::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int NUM_LANES = N,
    parameter int DEPTH     = 2,
    parameter int PRF_IDX_W = PRF_IDX_W_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
`ifdef CDB_AGE_PRIO_EN
    input  logic [ROB_IDX_W-1:0]           rob_head,
`endif
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_prf_idx,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]      req_value,
    output logic [NUM_LANES-1:0]           cdb_valid,
    output logic [NUM_LANES*PRF_IDX_W-1:0] cdb_prf_idx,
    output logic [NUM_LANES*ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [NUM_LANES*DATA_W-1:0]    cdb_value,
    output logic [NUM_REQ-1:0]             grant_debug
);

    typedef struct packed {
        logic [PRF_IDX_W-1:0] prf_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    value;
    } fu_req_t;

    typedef struct packed {
        logic                 valid;
        logic [PRF_IDX_W-1:0] prf_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    value;
    } cdb_lane_t;

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fu_req_t          req_pkt [NUM_REQ];
    fu_req_t          head    [NUM_REQ];
    logic [CNT_W-1:0] count   [NUM_REQ];
    logic [NUM_REQ-1:0] nonempty;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] avail;
    cdb_lane_t        lanes_d [NUM_LANES];
    cdb_lane_t        lanes_q [NUM_LANES];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_pkt[gi] = {req_prf_idx[gi*PRF_IDX_W +: PRF_IDX_W],
                              req_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W],
                              req_value[gi*DATA_W +: DATA_W]};

        cdb_req_fifo #(.DEPTH(DEPTH), .pkt_t(fu_req_t)) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .flush_i     (squash),
            .push_i      (req_valid[gi]),
            .push_data_i (req_pkt[gi]),
            .pop_i       (grant[gi]),
            .head_o      (head[gi]),
            .count_o     (count[gi]),
            .ready_o     (req_ready[gi])
        );

        assign nonempty[gi] = (count[gi] != '0);
    end

`ifdef CDB_AGE_PRIO_EN
    logic [ROB_IDX_W-1:0] age [NUM_REQ];
    logic [ROB_IDX_W-1:0] best_age;
    logic [IDX_W-1:0]     best_idx;
    logic                 best_found;

    // Each lane takes the oldest remaining head; strict '<' keeps ties on the lower index.
    always_comb begin
        avail      = nonempty;
        grant      = '0;
        best_age   = '0;
        best_idx   = '0;
        best_found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) lanes_d[k] = '0;
        for (int i = 0; i < NUM_REQ; i++) age[i] = head[i].rob_idx - rob_head;
        for (int k = 0; k < NUM_LANES; k++) begin
            best_found = 1'b0;
            best_idx   = '0;
            best_age   = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (avail[i] && (!best_found || age[i] < best_age)) begin
                    best_found = 1'b1;
                    best_idx   = IDX_W'(i);
                    best_age   = age[i];
                end
            end
            if (best_found) begin
                avail[best_idx] = 1'b0;
                grant[best_idx] = 1'b1;
                lanes_d[k]      = {1'b1, head[best_idx]};
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]   scan;
    logic [IDX_W-1:0] idx, last_idx;
    logic             any_grant, lane_done;

    // Lane k takes the k-th non-empty head found scanning upward from rr_ptr.
    always_comb begin
        avail     = nonempty;
        grant     = '0;
        scan      = '0;
        idx       = '0;
        last_idx  = rr_ptr_q;
        any_grant = 1'b0;
        lane_done = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) lanes_d[k] = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_done = 1'b0;
            for (int off = 0; off < NUM_REQ; off++) begin
                scan = {1'b0, rr_ptr_q} + (IDX_W + 1)'(off);
                if (scan >= (IDX_W + 1)'(NUM_REQ)) scan = scan - (IDX_W + 1)'(NUM_REQ);
                idx = scan[IDX_W-1:0];
                if (!lane_done && avail[idx]) begin
                    lane_done  = 1'b1;
                    avail[idx] = 1'b0;
                    grant[idx] = 1'b1;
                    lanes_d[k] = {1'b1, head[idx]};
                    last_idx   = idx;
                    any_grant  = 1'b1;
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any_grant) rr_ptr_d = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end

    // Squash keeps the pointer so fairness survives a flush.
    always_ff @(posedge clock) begin
        if (reset)        rr_ptr_q <= '0;
        else if (!squash) rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lanes_q[k] <= (reset || squash) ? '0 : lanes_d[k];
        end
    end

    for (genvar gk = 0; gk < NUM_LANES; gk++) begin : g_lane
        assign cdb_valid[gk]                          = lanes_q[gk].valid;
        assign cdb_prf_idx[gk*PRF_IDX_W +: PRF_IDX_W] = lanes_q[gk].prf_idx;
        assign cdb_rob_idx[gk*ROB_IDX_W +: ROB_IDX_W] = lanes_q[gk].rob_idx;
        assign cdb_value[gk*DATA_W +: DATA_W]         = lanes_q[gk].value;
    end

    assign grant_debug = (reset || squash) ? '0 : grant;

endmodule
